// File: rtl/rotation_frame_ctrl.sv
// Frame sequencer for the rotation address generator.
// Holds the rotation angle (manual step pulses plus an optional per-frame auto spin).
// On each frame request it looks up Q2.14 sin/cos from a quarter-wave table,
// holds the generator in reset while the coefficients settle, then lets the
// generator run until it reports frame-done or the timeout expires.
module rotation_frame_ctrl #(
  parameter int ANGLE_STEP     = 1,
  parameter int AUTO_DIV       = 0,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_req,
  input  logic               angle_inc,
  input  logic               angle_dec,
  input  logic               auto_en,
  input  logic               gen_frame_done,
  output logic               gen_rst,
  output logic signed [15:0] sin_a,
  output logic signed [15:0] cos_a,
  output logic [8:0]         angle,
  output logic               busy,
  output logic               overrun,
  output logic               timeout
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LUT, S_APPLY, S_RUN} state_t;

  localparam logic [9:0]  STEP      = 10'(ANGLE_STEP);
  localparam logic [7:0]  AUTO_LAST = 8'(AUTO_DIV - 1);
  localparam logic        AUTO_ON   = (AUTO_DIV != 0);
  localparam logic [23:0] TO_LAST   = 24'(TIMEOUT_CYCLES - 1);
  localparam logic        TO_ON     = (TIMEOUT_CYCLES != 0);

  // round(16384 * sin(k deg)), k = 0..90
  localparam logic [15:0] SIN_TAB [0:90] = '{
    16'd0,     16'd286,   16'd572,   16'd857,   16'd1143,  16'd1428,  16'd1713,  16'd1997,  16'd2280,  16'd2563,
    16'd2845,  16'd3126,  16'd3406,  16'd3686,  16'd3964,  16'd4240,  16'd4516,  16'd4790,  16'd5063,  16'd5334,
    16'd5604,  16'd5872,  16'd6138,  16'd6402,  16'd6664,  16'd6924,  16'd7182,  16'd7438,  16'd7692,  16'd7943,
    16'd8192,  16'd8438,  16'd8682,  16'd8923,  16'd9162,  16'd9397,  16'd9630,  16'd9860,  16'd10087, 16'd10311,
    16'd10531, 16'd10749, 16'd10963, 16'd11174, 16'd11381, 16'd11585, 16'd11786, 16'd11982, 16'd12176, 16'd12365,
    16'd12551, 16'd12733, 16'd12911, 16'd13085, 16'd13255, 16'd13421, 16'd13583, 16'd13741, 16'd13894, 16'd14044,
    16'd14189, 16'd14330, 16'd14466, 16'd14598, 16'd14726, 16'd14849, 16'd14968, 16'd15082, 16'd15191, 16'd15296,
    16'd15396, 16'd15491, 16'd15582, 16'd15668, 16'd15749, 16'd15826, 16'd15897, 16'd15964, 16'd16026, 16'd16083,
    16'd16135, 16'd16182, 16'd16225, 16'd16262, 16'd16294, 16'd16322, 16'd16344, 16'd16362, 16'd16374, 16'd16382,
    16'd16384
  };

  state_t      state;
  logic [1:0]  quad;
  logic [6:0]  rem;
  logic [15:0] s_r, s_c;
  logic [7:0]  fcnt;
  logic [23:0] tcnt;

  logic        done_ok, auto_hit;
  logic [9:0]  ang_up, ang_dn;
  logic [8:0]  ang_inc_w, ang_dec_w;
  logic [1:0]  q_w;
  logic [6:0]  r_w;
  logic [15:0] sin_mag, cos_mag;
  logic        sin_neg, cos_neg;

  assign done_ok   = (state == S_RUN) && gen_frame_done;
  assign auto_hit  = AUTO_ON && auto_en && done_ok && (fcnt == AUTO_LAST);
  assign ang_up    = {1'b0, angle} + STEP;
  assign ang_inc_w = (ang_up >= 10'd360) ? 9'(ang_up - 10'd360) : ang_up[8:0];
  assign ang_dn    = ({1'b0, angle} < STEP) ? ({1'b0, angle} + 10'd360 - STEP)
                                            : ({1'b0, angle} - STEP);
  assign ang_dec_w = ang_dn[8:0];

  // Quadrant sign/mirror selection: odd quadrants read the mirrored entry.
  assign sin_mag = quad[0] ? s_c : s_r;
  assign cos_mag = quad[0] ? s_r : s_c;
  assign sin_neg = quad[1];
  assign cos_neg = quad[0] ^ quad[1];

  // Quadrant split by compare chain; no divider needed for a 0..359 range.
  always_comb begin
    q_w = 2'd0;
    r_w = 7'(angle);
    if (angle >= 9'd270) begin
      q_w = 2'd3;
      r_w = 7'(angle - 9'd270);
    end else if (angle >= 9'd180) begin
      q_w = 2'd2;
      r_w = 7'(angle - 9'd180);
    end else if (angle >= 9'd90) begin
      q_w = 2'd1;
      r_w = 7'(angle - 9'd90);
    end
  end

  // Angle register and auto-spin frame counter; manual pulses override an auto step.
  always_ff @(posedge clk) begin
    if (rst) begin
      angle <= 9'd0;
      fcnt  <= 8'd0;
    end else begin
      if (angle_inc && !angle_dec)                   angle <= ang_inc_w;
      else if (angle_dec && !angle_inc)              angle <= ang_dec_w;
      else if (auto_hit && !angle_inc && !angle_dec) angle <= ang_inc_w;
      if (!auto_en || !AUTO_ON) fcnt <= 8'd0;
      else if (done_ok)         fcnt <= auto_hit ? 8'd0 : fcnt + 8'd1;
    end
  end

  // Two registered table read ports, sampled while in LUT.
  always_ff @(posedge clk) begin
    if (state == S_LUT) begin
      s_r <= SIN_TAB[rem];
      s_c <= SIN_TAB[7'd90 - rem];
    end
  end

  // Frame sequencer; coefficients only move on the edge that releases gen_rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      gen_rst <= 1'b1;
      sin_a   <= 16'sd0;
      cos_a   <= 16'sd16384;
      busy    <= 1'b0;
      overrun <= 1'b0;
      timeout <= 1'b0;
      tcnt    <= 24'd0;
      quad    <= 2'd0;
      rem     <= 7'd0;
    end else begin
      overrun <= frame_req && (state != S_IDLE);
      timeout <= 1'b0;
      case (state)
        S_IDLE: if (frame_req) begin
          state   <= S_LOAD;
          gen_rst <= 1'b1;
          busy    <= 1'b1;
        end
        S_LOAD: begin
          quad  <= q_w;
          rem   <= r_w;
          state <= S_LUT;
        end
        S_LUT: state <= S_APPLY;
        S_APPLY: begin
          sin_a   <= sin_neg ? 16'(-sin_mag) : sin_mag;
          cos_a   <= cos_neg ? 16'(-cos_mag) : cos_mag;
          gen_rst <= 1'b0;
          tcnt    <= 24'd0;
          state   <= S_RUN;
        end
        S_RUN: begin
          if (gen_frame_done) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (TO_ON && tcnt == TO_LAST) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end else begin
            tcnt <= tcnt + 24'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
